// File: rtl/inst_buffer_pkg.sv
// Shared widths, stall encodings and bus layouts for the IF->IB->ID instruction buffer.
package inst_buffer_pkg;

    localparam int IF_TO_IB_WD = 66;
    localparam int IB_TO_ID_WD = 65;
    localparam int STALLBUS_WD = 6;
    localparam int IB_DEPTH    = 8;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic        discard;
        logic        ce;
        logic [31:0] pc_idef;
        logic [31:0] pc_fetch;
    } if_to_ib_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

    typedef struct packed {
        logic      valid;
        ib_entry_t entry;
    } ib_to_id_t;

    typedef struct packed {
        logic        v;
        logic        disc;
        logic [31:0] idef;
        logic [31:0] pc;
    } resp_t;

endpackage

// File: rtl/ib_fifo2w1r.sv
// Circular instruction store: up to two writes and one read per cycle, with registered
// occupancy and free-entry counts. Writes beyond capacity are dropped.
module ib_fifo2w1r
    import inst_buffer_pkg::*;
#(
    parameter  int DEPTH = IB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic [1:0]      wr_cnt,
    input  ib_entry_t       wr_data0,
    input  ib_entry_t       wr_data1,
    input  logic            rd_en,
    output ib_entry_t       rd_data,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   free
);

    ib_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, wptr_p1;
    logic [CW-1:0]     count_q, count_d, free_q, free_d, space;
    logic [1:0]        n_acc;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        space   = CW'(DEPTH) - count_q + CW'(rd_en);
        n_acc   = wr_cnt;
        if (CW'(wr_cnt) > space) begin
            n_acc = space[1:0];
        end
        wptr_p1 = wptr_q + PW'(1);
        wptr_d  = wptr_q + PW'(n_acc);
        rptr_d  = rptr_q + PW'(rd_en);
        count_d = count_q + CW'(n_acc) - CW'(rd_en);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        free_d = CW'(DEPTH) - count_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            free_q  <= CW'(DEPTH);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            free_q  <= free_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (n_acc != 2'd0) mem_q[wptr_q]  <= wr_data0;
            if (n_acc == 2'd2) mem_q[wptr_p1] <= wr_data1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            assert (CW'(wr_cnt) <= space);
        end
    end
`endif

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;
    assign free    = free_q;

endmodule

// File: rtl/inst_buffer.sv
// IF->IB receiver: aligns fetch descriptors with SRAM data, unpacks pairs into a FIFO and
// issues one instruction per cycle to ID. Optional same-cycle bypass with IB_BYPASS_EN.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH      = IB_DEPTH,
    parameter int STALL_FREE = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [STALLBUS_WD-1:0] stall,
    input  logic                   flush,
    input  logic [IF_TO_IB_WD-1:0] if_to_ib_bus,
    input  logic [63:0]            inst_sram_rdata,
    output logic [IB_TO_ID_WD-1:0] ib_to_id_bus,
    output logic                   stallreq_ib
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_to_ib_t     fetch;
    resp_t         resp_q, resp_d;
    ib_entry_t     lo_entry, hi_entry, wr0, wr1, fifo_wr0, head;
    ib_to_id_t     out;
    logic          hold, pair_ok, lo_en, fifo_rd;
    logic [1:0]    wr_cnt, fifo_wr_cnt;
    logic [CW-1:0] fifo_count, fifo_free;
    logic          unused_bits;

    assign fetch = if_to_ib_t'(if_to_ib_bus);

    always_comb begin
        resp_d.v    = fetch.ce & ~flush;
        resp_d.disc = fetch.discard;
        resp_d.idef = fetch.pc_idef;
        resp_d.pc   = fetch.pc_fetch;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    // The SRAM data for resp_q arrives this cycle; lo is dropped when entry was the odd word.
    always_comb begin
        hold          = (stall[1] == STOP);
        lo_entry.pc   = resp_q.pc;
        lo_entry.inst = inst_sram_rdata[31:0];
        hi_entry.pc   = resp_q.pc + 32'd4;
        hi_entry.inst = inst_sram_rdata[63:32];
        pair_ok       = resp_q.v & ~resp_q.disc & ~flush;
        lo_en         = pair_ok & ~resp_q.idef[2];
        wr_cnt        = {1'b0, lo_en} + {1'b0, pair_ok};
        wr0           = lo_en ? lo_entry : hi_entry;
        wr1           = hi_entry;

        out.valid     = (fifo_count != '0);
        out.entry     = head;
        fifo_rd       = out.valid & ~hold;
        fifo_wr_cnt   = wr_cnt;
        fifo_wr0      = wr0;
`ifdef IB_BYPASS_EN
        if (!out.valid && wr_cnt != 2'd0) begin
            out.valid = 1'b1;
            out.entry = wr0;
            if (!hold) begin
                fifo_wr_cnt = wr_cnt - 2'd1;
                fifo_wr0    = wr1;
            end
        end
`endif
    end

    ib_fifo2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .wr_cnt   (fifo_wr_cnt),
        .wr_data0 (fifo_wr0),
        .wr_data1 (wr1),
        .rd_en    (fifo_rd),
        .rd_data  (head),
        .count    (fifo_count),
        .free     (fifo_free)
    );

    assign ib_to_id_bus = out;
    assign stallreq_ib  = (fifo_free < CW'(STALL_FREE));

    assign unused_bits = ^{stall[STALLBUS_WD-1:2], stall[0],
                           resp_q.idef[31:3], resp_q.idef[1:0]};

endmodule

// File: tb/tb_inst_buffer.sv
// Directed, table-driven bench for inst_buffer (default build, DEPTH=8, STALL_FREE=4).
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [STALLBUS_WD-1:0] stall;
    logic                   flush;
    logic [IF_TO_IB_WD-1:0] if_to_ib_bus;
    logic [63:0]            inst_sram_rdata;
    logic [IB_TO_ID_WD-1:0] ib_to_id_bus;
    logic                   stallreq_ib;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(8), .STALL_FREE(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .flush           (flush),
        .if_to_ib_bus    (if_to_ib_bus),
        .inst_sram_rdata (inst_sram_rdata),
        .ib_to_id_bus    (ib_to_id_bus),
        .stallreq_ib     (stallreq_ib)
    );

    wire        out_valid = ib_to_id_bus[64];
    wire [31:0] out_pc    = ib_to_id_bus[63:32];
    wire [31:0] out_inst  = ib_to_id_bus[31:0];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ce;
        logic        disc;
        logic [31:0] idef;
        logic [31:0] pc;
        logic [63:0] rdata;
        logic        stop;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_stallreq;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic disc, input logic [31:0] idef,
                         input logic [31:0] pc, input logic [63:0] rdata,
                         input logic stop, input logic fl);
        if_to_ib_bus    = {disc, ce, idef, pc};
        inst_sram_rdata = rdata;
        stall           = {4'b0, stop, 1'b0};
        flush           = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ce, input logic disc, input logic [31:0] idef,
                                input logic [31:0] pc, input logic [63:0] rdata, input logic stop,
                                input logic ev, input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.ce = ce; v.disc = disc; v.idef = idef; v.pc = pc; v.rdata = rdata; v.stop = stop;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_inst = einst; v.exp_stallreq = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] fill_inst(input int i);
        return 32'ha000_0000 + 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int model_cnt;
        int k;
        logic prev_ce;
        logic ce_now;

        // Each row is one cycle; rdata belongs to the previous row's fetch.
        vecs[0]  = mk(1, 0, 32'hbfc00000, 32'hbfc00000, 64'h0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 64'h24020002_24010001, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 64'h0, 0, 1, 32'hbfc00000, 32'h24010001);
        vecs[3]  = mk(0, 0, 0, 0, 64'h0, 0, 1, 32'hbfc00004, 32'h24020002);
        vecs[4]  = mk(1, 0, 32'hbfc00014, 32'hbfc00010, 64'h0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 64'h11111111_22222222, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 64'h0, 1, 1, 32'hbfc00014, 32'h11111111);
        vecs[7]  = mk(0, 0, 0, 0, 64'h0, 0, 1, 32'hbfc00014, 32'h11111111);
        vecs[8]  = mk(1, 1, 32'hbfc00020, 32'hbfc00020, 64'h0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 64'h33333333_44444444, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 64'h0, 0, 0, 0, 0);

        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_stallreq", 64'(stallreq_ib), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ce, vecs[i].disc, vecs[i].idef, vecs[i].pc, vecs[i].rdata, vecs[i].stop, 0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(vecs[i].exp_pc));
                check($sformatf("vec%0d_inst", i), 64'(out_inst), 64'(vecs[i].exp_inst));
            end
            check($sformatf("vec%0d_stallreq", i), 64'(stallreq_ib), 64'(vecs[i].exp_stallreq));
            tick();
        end

        // Fill under Stop with IF obeying stallreq_ib; up to six pairs are offered.
        model_cnt = 0;
        k = 0;
        prev_ce = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ce_now = !stallreq_ib && (k < 6);
            drive(ce_now, 0, 32'h1000 + 32'(8 * k), 32'h1000 + 32'(8 * k),
                  prev_ce ? {fill_inst(2 * k - 1), fill_inst(2 * k - 2)} : 64'h0, 1, 0);
            @(negedge clk);
            check($sformatf("fill%0d_stallreq", c), 64'(stallreq_ib), 64'((8 - model_cnt) < 4));
            check($sformatf("fill%0d_valid", c), 64'(out_valid), 64'(model_cnt != 0));
            tick();
            if (prev_ce) model_cnt += 2;
            prev_ce = ce_now;
            if (ce_now) k++;
        end
        check("fill_level", 64'(model_cnt), 64'd8);

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
            check($sformatf("drain%0d_inst", i), 64'(out_inst), 64'(fill_inst(i)));
            check($sformatf("drain%0d_stallreq", i), 64'(stallreq_ib), 64'(i < 4));
            tick();
        end
        @(negedge clk);
        check("drain_empty_valid", 64'(out_valid), 64'd0);
        tick();

        // Flush with six queued entries and a pair in flight.
        for (int p = 0; p < 4; p++) begin
            drive(1, 0, 32'h2000 + 32'(8 * p), 32'h2000 + 32'(8 * p),
                  p == 0 ? 64'h0 : {32'hc000_0000 + 32'(2 * p - 1), 32'hc000_0000 + 32'(2 * p - 2)}, 1, 0);
            tick();
        end
        drive(1, 0, 32'h2020, 32'h2020, 64'hc0000007_c0000006, 1, 1);
        @(negedge clk);
        check("preflush_valid", 64'(out_valid), 64'd1);
        check("preflush_pc", 64'(out_pc), 64'h2000);
        check("preflush_stallreq", 64'(stallreq_ib), 64'd1);
        tick();
        drive(1, 0, 32'hbfc00380, 32'hbfc00380, 64'hdeadbeef_deadbeef, 0, 0);
        @(negedge clk);
        check("postflush_valid", 64'(out_valid), 64'd0);
        check("postflush_stallreq", 64'(stallreq_ib), 64'd0);
        tick();
        drive(0, 0, 0, 0, 64'h3c1b0000_401a6000, 0, 0);
        @(negedge clk);
        check("newpc_wait_valid", 64'(out_valid), 64'd0);
        tick();
        drive(0, 0, 0, 0, 64'h0, 0, 0);
        @(negedge clk);
        check("newpc_lo_valid", 64'(out_valid), 64'd1);
        check("newpc_lo_pc", 64'(out_pc), 64'hbfc00380);
        check("newpc_lo_inst", 64'(out_inst), 64'h401a6000);
        tick();
        @(negedge clk);
        check("newpc_hi_pc", 64'(out_pc), 64'hbfc00384);
        check("newpc_hi_inst", 64'(out_inst), 64'h3c1b0000);
        tick();
        @(negedge clk);
        check("newpc_done_valid", 64'(out_valid), 64'd0);
        tick();

        // Asynchronous reset mid-stream with six entries queued.
        for (int p = 0; p < 4; p++) begin
            drive(p < 3, 0, 32'h3000 + 32'(8 * p), 32'h3000 + 32'(8 * p), 64'h55555555_66666666, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("prereset_valid", 64'(out_valid), 64'd1);
        check("prereset_stallreq", 64'(stallreq_ib), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_stallreq", 64'(stallreq_ib), 64'd0);
        tick();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        check("after_reset_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
